// File: rtl/branch_resolve_predictor.sv
// EX-stage BEQ resolution with a PC-indexed table of 2-bit saturating predictors.
// Flags mispredictions combinationally and keeps saturating branch/mispredict statistics.
module branch_resolve_predictor #(
    parameter int         IDX_BITS   = 4,
    parameter logic [1:0] INIT_STATE = 2'b11,
    parameter int         COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        lookup_pc_i,
    output logic               predict_taken_o,
    input  logic               branch_e_i,
    input  logic               predict_e_i,
    input  logic [31:0]        rs1_e_i,
    input  logic [31:0]        rs2_e_i,
    input  logic [31:0]        pc_e_i,
    input  logic [31:0]        pc_notchosen_e_i,
    input  logic               stall_i,
    output logic               mispredict_o,
    output logic [31:0]        redirect_pc_o,
    output logic [COUNT_W-1:0] branch_count_o,
    output logic [COUNT_W-1:0] mispredict_count_o
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          table_q [ENTRIES];
    logic [1:0]          table_d [ENTRIES];
    logic [COUNT_W-1:0]  branch_count_q, branch_count_d;
    logic [COUNT_W-1:0]  mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] update_idx;
    logic                resolve;
    logic                taken;

    assign lookup_idx = lookup_pc_i[IDX_BITS+1:2];
    assign update_idx = pc_e_i[IDX_BITS+1:2];

    // Only the index bits matter; the rest alias by design (no tag check).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[31:IDX_BITS+2], lookup_pc_i[1:0],
                              pc_e_i[31:IDX_BITS+2], pc_e_i[1:0]};

    // Gating with reset keeps the flush request quiet while the unit is held in reset.
    assign resolve = branch_e_i & ~stall_i & reset;
    assign taken   = (rs1_e_i == rs2_e_i);

    assign mispredict_o       = resolve & (taken != predict_e_i);
    assign redirect_pc_o      = pc_notchosen_e_i;
    assign predict_taken_o    = table_q[lookup_idx][1];
    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

    always_comb begin
        table_d            = table_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (resolve) begin
            if (taken) begin
                if (table_q[update_idx] != 2'b11) begin
                    table_d[update_idx] = table_q[update_idx] + 2'b01;
                end
            end else begin
                if (table_q[update_idx] != 2'b00) begin
                    table_d[update_idx] = table_q[update_idx] - 2'b01;
                end
            end
            if (branch_count_q != {COUNT_W{1'b1}}) begin
                branch_count_d = branch_count_q + 1'b1;
            end
            if (mispredict_o && (mispredict_count_q != {COUNT_W{1'b1}})) begin
                mispredict_count_d = mispredict_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= INIT_STATE;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            table_q            <= table_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_predictor.sv
// Directed bench for branch_resolve_predictor: a default-width instance and a
// 3-bit-counter instance share the same stimulus.
module tb_branch_resolve_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        branch_e;
    logic        predict_e;
    logic [31:0] rs1_e;
    logic [31:0] rs2_e;
    logic [31:0] pc_e;
    logic [31:0] pc_nc_e;
    logic        stall;

    logic        predict_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    logic        s_predict_taken;
    logic        s_mispredict;
    logic [31:0] s_redirect_pc;
    logic [2:0]  s_branch_count;
    logic [2:0]  s_mispredict_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_predictor dut (
        .clk                (clk),
        .reset              (reset),
        .lookup_pc_i        (lookup_pc),
        .predict_taken_o    (predict_taken),
        .branch_e_i         (branch_e),
        .predict_e_i        (predict_e),
        .rs1_e_i            (rs1_e),
        .rs2_e_i            (rs2_e),
        .pc_e_i             (pc_e),
        .pc_notchosen_e_i   (pc_nc_e),
        .stall_i            (stall),
        .mispredict_o       (mispredict),
        .redirect_pc_o      (redirect_pc),
        .branch_count_o     (branch_count),
        .mispredict_count_o (mispredict_count)
    );

    branch_resolve_predictor #(.COUNT_W(3)) dut_s (
        .clk                (clk),
        .reset              (reset),
        .lookup_pc_i        (lookup_pc),
        .predict_taken_o    (s_predict_taken),
        .branch_e_i         (branch_e),
        .predict_e_i        (predict_e),
        .rs1_e_i            (rs1_e),
        .rs2_e_i            (rs2_e),
        .pc_e_i             (pc_e),
        .pc_notchosen_e_i   (pc_nc_e),
        .stall_i            (stall),
        .mispredict_o       (s_mispredict),
        .redirect_pc_o      (s_redirect_pc),
        .branch_count_o     (s_branch_count),
        .mispredict_count_o (s_mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one EX-stage branch slot shortly after a falling edge.
    task automatic drive(input logic br, input logic pr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] nc, input logic st);
        @(negedge clk);
        branch_e  = br;
        predict_e = pr;
        rs1_e     = a;
        rs2_e     = b;
        pc_e      = pc;
        pc_nc_e   = nc;
        stall     = st;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        lookup_pc = 32'h10;
        branch_e  = 1'b0;
        predict_e = 1'b0;
        rs1_e     = '0;
        rs2_e     = '0;
        pc_e      = '0;
        pc_nc_e   = '0;
        stall     = 1'b0;
        #12;
        check("rst_predict", {31'b0, predict_taken}, 32'd1);
        check("rst_bcnt", branch_count, 32'd0);
        check("rst_mcnt", mispredict_count, 32'd0);
        check("rst_mispred", {31'b0, mispredict}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Not-taken branch predicted taken: entry 4 goes 11 -> 10.
        drive(1'b1, 1'b1, 32'd5, 32'd7, 32'h10, 32'h14, 1'b0);
        check("t2_mispred", {31'b0, mispredict}, 32'd1);
        check("t2_redirect", redirect_pc, 32'h14);
        after_edge();
        check("t2_bcnt", branch_count, 32'd1);
        check("t2_mcnt", mispredict_count, 32'd1);
        check("t2_predict_10", {31'b0, predict_taken}, 32'd1);

        // Three correctly-predicted not-taken: 10 -> 01 -> 00 -> 00.
        drive(1'b1, 1'b0, 32'd5, 32'd7, 32'h10, 32'h14, 1'b0);
        check("t3_no_mispred", {31'b0, mispredict}, 32'd0);
        after_edge();
        check("t3_predict_01", {31'b0, predict_taken}, 32'd0);
        drive(1'b1, 1'b0, 32'd5, 32'd7, 32'h10, 32'h14, 1'b0);
        after_edge();
        drive(1'b1, 1'b0, 32'd5, 32'd7, 32'h10, 32'h14, 1'b0);
        after_edge();
        check("t3_predict_00", {31'b0, predict_taken}, 32'd0);
        check("t3_bcnt", branch_count, 32'd4);
        check("t3_mcnt", mispredict_count, 32'd1);

        // Stalled taken branch: nothing resolves for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd9, 32'd9, 32'h10, 32'h14, 1'b1);
            check("t4_stall_mispred", {31'b0, mispredict}, 32'd0);
            after_edge();
            check("t4_stall_bcnt", branch_count, 32'd4);
        end
        check("t4_stall_mcnt", mispredict_count, 32'd1);
        check("t4_stall_predict", {31'b0, predict_taken}, 32'd0);
        drive(1'b1, 1'b0, 32'd9, 32'd9, 32'h10, 32'h14, 1'b0);
        check("t4_unstall_mispred", {31'b0, mispredict}, 32'd1);
        after_edge();
        check("t4_bcnt", branch_count, 32'd5);
        check("t4_mcnt", mispredict_count, 32'd2);
        check("t4_predict_01", {31'b0, predict_taken}, 32'd0);

        // Same-cycle lookup and taken update of entry 4 (01): old value, then new.
        drive(1'b1, 1'b1, 32'd3, 32'd3, 32'h10, 32'h14, 1'b0);
        check("t5_no_bypass", {31'b0, predict_taken}, 32'd0);
        check("t5_no_mispred", {31'b0, mispredict}, 32'd0);
        after_edge();
        check("t5_new_value", {31'b0, predict_taken}, 32'd1);
        check("t5_bcnt", branch_count, 32'd6);
        lookup_pc = 32'h50;
        #1;
        check("alias_0x50", {31'b0, predict_taken}, 32'd1);
        lookup_pc = 32'h18;
        #1;
        check("untouched_0x18", {31'b0, predict_taken}, 32'd1);

        // Bubble with mismatched operands/prediction: no flush, no count.
        drive(1'b0, 1'b1, 32'd1, 32'd2, 32'h10, 32'h14, 1'b0);
        check("bubble_mispred", {31'b0, mispredict}, 32'd0);
        after_edge();
        check("bubble_bcnt", branch_count, 32'd6);
        lookup_pc = 32'h10;
        #1;
        check("bubble_predict", {31'b0, predict_taken}, 32'd1);

        // Eight mispredicts at 0x20; operands differ only in bit 31.
        lookup_pc = 32'h20;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'h8000_0001, 32'h0000_0001, 32'h20, 32'h24, 1'b0);
            check("t6_mispred", {31'b0, mispredict}, 32'd1);
            after_edge();
        end
        check("t6_bcnt", branch_count, 32'd14);
        check("t6_mcnt", mispredict_count, 32'd10);
        check("t6_small_bcnt_sat", {29'b0, s_branch_count}, 32'd7);
        check("t6_small_mcnt_sat", {29'b0, s_mispredict_count}, 32'd7);
        check("t6_predict_20", {31'b0, predict_taken}, 32'd0);

        // Asynchronous reset mid-cycle, with a mispredicting branch still presented.
        drive(1'b1, 1'b1, 32'd1, 32'd2, 32'h20, 32'h24, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("arst_bcnt", branch_count, 32'd0);
        check("arst_mcnt", mispredict_count, 32'd0);
        check("arst_small_bcnt", {29'b0, s_branch_count}, 32'd0);
        check("arst_predict_20", {31'b0, predict_taken}, 32'd1);
        check("arst_mispred", {31'b0, mispredict}, 32'd0);
        after_edge();
        check("arst_hold_bcnt", branch_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_mispred", {31'b0, mispredict}, 32'd1);
        after_edge();
        check("rel_bcnt", branch_count, 32'd1);
        check("rel_mcnt", mispredict_count, 32'd1);
        check("rel_predict_20", {31'b0, predict_taken}, 32'd1);
        branch_e = 1'b0;
        after_edge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
